branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 33 +++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/bp_btb.sv | 47 ++++
 rtl/branch_predictor.sv | 70 +++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared encodings, sizes and counter helper for the branch predictor
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // Branch type codes shared with the EX compare unit; 3'b000/3'b001 are non-conditional.
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam int DEF_BHT_ENTRIES = 64;
    localparam int DEF_BTB_ENTRIES = 16;

    function automatic logic is_cond_branch(input logic [2:0] br_type);
        return br_type >= BR_BEQ;
    endfunction

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) nxt = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
        else       nxt = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX resolve and redirect signals of the branch predictor
interface branch_predictor_if;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [2:0]  ex_type;
    logic        ex_bre;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic        redirect;
    logic [63:0] redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_type, ex_bre, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect, redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_type, ex_bre, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect, redirect_pc
    );
endinterface

// File: rtl/bp_btb.sv
// rtl/bp_btb.sv - direct-mapped branch target buffer with one combinational read and one write port
module bp_btb
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = DEF_BTB_ENTRIES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:2] rd_pc,
    output logic        rd_hit,
    output logic [63:0] rd_target,
    input  logic        wr_en,
    input  logic [63:2] wr_pc,
    input  logic [63:0] wr_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 62 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [63:0]        target_mem [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx    = rd_pc[IDX_W+1:2];
    assign wr_idx    = wr_pc[IDX_W+1:2];
    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_pc[63:IDX_W+2]);
    assign rd_target = target_mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_pc[63:IDX_W+2];
            target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal direction predictor with BTB and registered mispredict redirect
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_ENTRIES = DEF_BHT_ENTRIES,
    parameter int BTB_ENTRIES = DEF_BTB_ENTRIES
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int BHT_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [BHT_W-1:0] rd_idx;
    logic [BHT_W-1:0] wr_idx;
    logic             btb_hit;
    logic [63:0]      btb_target;
    logic             update;
    logic             mispredict;
    logic [63:0]      fix_pc;

    assign rd_idx = bp.if_pc[BHT_W+1:2];
    assign wr_idx = bp.ex_pc[BHT_W+1:2];
    assign update = bp.ex_valid && is_cond_branch(bp.ex_type);

    assign mispredict = (bp.ex_bre != bp.ex_pred_taken) ||
                        (bp.ex_bre && bp.ex_pred_taken && (bp.ex_pred_target != bp.ex_target));
    assign fix_pc     = bp.ex_bre ? bp.ex_target : bp.ex_pc + 64'd4;

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (bp.if_pc[63:2]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (update && bp.ex_bre),
        .wr_pc     (bp.ex_pc[63:2]),
        .wr_target (bp.ex_target)
    );

    // Reads come straight from the arrays, so a same-cycle update is not visible until the next cycle.
    assign bp.pred_taken  = btb_hit && bht[rd_idx][1];
    assign bp.pred_target = bp.pred_taken ? btb_target : bp.if_pc + 64'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_WNT;
            end
        end else if (update) begin
            bht[wr_idx] <= cnt_next(bht[wr_idx], bp.ex_bre);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.redirect    <= 1'b0;
            bp.redirect_pc <= '0;
        end else begin
            bp.redirect <= update && mispredict;
            if (update && mispredict) begin
                bp.redirect_pc <= fix_pc;
            end
        end
    end

endmodule
